// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word over a req/ack
// handshake and holds it in the instruction register for decode.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   fetch_start                request next instruction (IDLE/HOLD only)
//   pc_load, pc_load_addr      PC redirect for jumps/branches
//   mem_req, mem_addr          memory read request/address (held until ack)
//   mem_rdata, mem_ack         memory read data / data valid
//   instruction, instr_valid   instruction register and freshness flag
//   pc                         address of next fetch
//   busy                       fetch in flight
//   fetch_count, stall_count   perf counters (zero unless enabled)
//
// Build option: define IFETCH_PERF_CNT_EN to build the saturating
// fetch/stall counters; otherwise both count ports are tied to zero.

module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_d;
    logic              valid_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              busy_d;
    // PC redirect that arrived while a fetch was in flight
    logic              pend_v, pend_v_d;
    logic [ADDR_W-1:0] pend_a, pend_a_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            pend_v      <= 1'b0;
            pend_a      <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instruction <= instr_d;
            instr_valid <= valid_d;
            mem_req     <= req_d;
            mem_addr    <= addr_d;
            busy        <= busy_d;
            pend_v      <= pend_v_d;
            pend_a      <= pend_a_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        instr_d  = instruction;
        valid_d  = instr_valid;
        req_d    = mem_req;
        addr_d   = mem_addr;
        busy_d   = busy;
        pend_v_d = pend_v;
        pend_a_d = pend_a;
        unique case (state)
            IDLE, HOLD: begin
                // A same-cycle load redirects the fetch itself, so the
                // PC takes the load address now and increments on ack.
                if (pc_load) begin
                    pc_d = pc_load_addr;
                end
                if (fetch_start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    addr_d  = pc_load ? pc_load_addr : pc;
                end
            end
            REQ: begin
                if (pc_load) begin
                    pend_v_d = 1'b1;
                    pend_a_d = pc_load_addr;
                end
                if (mem_ack) begin
                    state_d  = HOLD;
                    instr_d  = mem_rdata;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    busy_d   = 1'b0;
                    pend_v_d = 1'b0;
                    if (pc_load) begin
                        pc_d = pc_load_addr;
                    end else if (pend_v) begin
                        pc_d = pend_a;
                    end else begin
                        pc_d = pc + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fcnt;
    logic [15:0] scnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt <= '0;
            scnt <= '0;
        end else if (state == REQ) begin
            if (mem_ack) begin
                if (fcnt != 16'hFFFF) begin
                    fcnt <= fcnt + 16'd1;
                end
            end else if (scnt != 16'hFFFF) begin
                scnt <= scnt + 16'd1;
            end
        end
    end

    assign fetch_count = fcnt;
    assign stall_count = scnt;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Inputs change and outputs are checked 1ns after each rising edge.

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] pc;
    logic        busy;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_start  (fetch_start),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .busy         (busy),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        fetch_start  = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 1'b0;

        // basic fetch, ack in the first request cycle
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 16'h0000);
        chk("t1_busy", busy, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0523;
        tick();
        mem_ack = 1'b0;
        chk("t1_instr", instruction, 16'h0523);
        chk("t1_valid", instr_valid, 1);
        chk("t1_pc", pc, 16'h0001);
        chk("t1_req_off", mem_req, 0);
        chk("t1_busy_off", busy, 0);

        // ack delayed three cycles
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", mem_req, 1);
            chk("t2_addr", mem_addr, 16'h0001);
            chk("t2_valid", instr_valid, 0);
            tick();
        end
        chk("t2_req4", mem_req, 1);
        chk("t2_addr4", mem_addr, 16'h0001);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        chk("t2_instr", instruction, 16'h1234);
        chk("t2_valid1", instr_valid, 1);
        chk("t2_pc", pc, 16'h0002);
`ifdef IFETCH_PERF_CNT_EN
        chk("t2_stall", stall_count, 3);
        chk("t2_fetch", fetch_count, 2);
`else
        chk("t2_stall", stall_count, 0);
        chk("t2_fetch", fetch_count, 0);
`endif

        // stray ack while holding is ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        chk("stray_instr", instruction, 16'h1234);
        chk("stray_req", mem_req, 0);
        chk("stray_pc", pc, 16'h0002);

        // load in HOLD leaves the instruction alone
        pc_load      = 1'b1;
        pc_load_addr = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        chk("ld_pc", pc, 16'hFFFF);
        chk("ld_instr", instruction, 16'h1234);
        chk("ld_valid", instr_valid, 1);

        // PC wrap
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t3_addr", mem_addr, 16'hFFFF);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0111;
        tick();
        mem_ack = 1'b0;
        chk("t3_pc", pc, 16'h0000);

        // load together with fetch_start
        fetch_start  = 1'b1;
        pc_load      = 1'b1;
        pc_load_addr = 16'h0040;
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        chk("t4_addr", mem_addr, 16'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        tick();
        mem_ack = 1'b0;
        chk("t4_pc", pc, 16'h0041);

        // loads during REQ, second overwrites the first
        fetch_start = 1'b1;
        tick();
        fetch_start  = 1'b0;
        pc_load      = 1'b1;
        pc_load_addr = 16'h0200;
        tick();
        pc_load_addr = 16'h0100;
        tick();
        pc_load = 1'b0;
        chk("t5_addr", mem_addr, 16'h0041);
        chk("t5_req", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hC3F0;
        tick();
        mem_ack = 1'b0;
        chk("t5_instr", instruction, 16'hC3F0);
        chk("t5_pc", pc, 16'h0100);

        // load in the ack cycle
        fetch_start = 1'b1;
        tick();
        fetch_start  = 1'b0;
        pc_load      = 1'b1;
        pc_load_addr = 16'h0300;
        mem_ack      = 1'b1;
        mem_rdata    = 16'h5555;
        tick();
        pc_load = 1'b0;
        mem_ack = 1'b0;
        chk("ldack_pc", pc, 16'h0300);
        chk("ldack_instr", instruction, 16'h5555);

        // reset mid-REQ with a pending load
        fetch_start = 1'b1;
        tick();
        fetch_start  = 1'b0;
        pc_load      = 1'b1;
        pc_load_addr = 16'h0777;
        tick();
        pc_load = 1'b0;
        chk("t6_req_pre", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("t6_req_drop", mem_req, 0);
        chk("t6_pc_rst", pc, 16'h0000);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("t6_valid", instr_valid, 0);
        chk("t6_instr", instruction, 0);
        chk("t6_pc", pc, 16'h0000);
        chk("t6_busy", busy, 0);
        chk("t6_fcnt", fetch_count, 0);
        chk("t6_scnt", stall_count, 0);

        // pending load must not survive reset
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t6b_addr", mem_addr, 16'h0000);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0abc;
        tick();
        mem_ack = 1'b0;
        chk("t6b_pc", pc, 16'h0001);
        chk("t6b_instr", instruction, 16'h0abc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
